ff_pulse_scheduler: RTL and testbench

//   Shares one set/reset flipflop (edge-triggered on set/reset rising edges, set dominant)

---
 rtl/ff_pulse_scheduler.sv | 165 ++++++++++++++++
 tb/tb_ff_pulse_scheduler.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ff_pulse_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ff_pulse_scheduler: round-robin sharing of one set/reset flipflop with     |
// | non-overlapping, gap-separated pulses and a registered state mirror.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ff_pulse_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int PULSE_CYCLES   = 2,
  parameter int GAP_CYCLES     = 1,
  parameter int SKIP_REDUNDANT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] req_op,
  output logic [NUM_REQ-1:0] ack,
  output logic               set_o,
  output logic               reset_o,
  output logic               ff_state,
  output logic               busy
);

  localparam int c_MAX_CYC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int c_CNT_W   = $clog2(c_MAX_CYC + 1);
  localparam int c_IDX_W   = $clog2(NUM_REQ);

  localparam logic [c_CNT_W-1:0] c_P_LAST = c_CNT_W'(PULSE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_G_LAST = c_CNT_W'(GAP_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_1  = c_CNT_W'(1);
  localparam logic [NUM_REQ-1:0] c_ONE    = NUM_REQ'(1);
  localparam logic [c_IDX_W-1:0] c_PTR_RST = c_IDX_W'(NUM_REQ - 1);

  localparam logic [1:0] c_ST_INIT  = 2'd0;
  localparam logic [1:0] c_ST_IDLE  = 2'd1;
  localparam logic [1:0] c_ST_PULSE = 2'd2;
  localparam logic [1:0] c_ST_GAP   = 2'd3;

  logic [1:0]         r_state,  w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt,    w_cnt_nxt;
  logic [c_IDX_W-1:0] r_ptr,    w_ptr_nxt;
  logic [c_IDX_W-1:0] r_idx,    w_idx_nxt;
  logic               r_op,     w_op_nxt;
  logic               r_ff,     w_ff_nxt;
  logic               r_set,    w_set_nxt;
  logic               r_reset,  w_reset_nxt;
  logic [NUM_REQ-1:0] r_ack,    w_ack_nxt;

  logic [c_IDX_W-1:0] w_gnt_idx;
  logic               w_any;
  logic               w_gnt_vld;
  logic               w_gnt_op;
  logic               w_skip;

  // Scan from farthest to nearest so the first set bit after the pointer wins.
  always_comb begin
    w_gnt_idx = r_ptr;
    w_any     = 1'b0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (req[(int'(r_ptr) + i) % NUM_REQ]) begin
        w_gnt_idx = c_IDX_W'((int'(r_ptr) + i) % NUM_REQ);
        w_any     = 1'b1;
      end
    end
  end

  // No new grant in the cycle a skipped request is being acked.
  assign w_gnt_vld = w_any && (r_state == c_ST_IDLE) && (r_ack == '0);
  assign w_gnt_op  = req_op[w_gnt_idx];
  assign w_skip    = (SKIP_REDUNDANT != 0) && (w_gnt_op == r_ff);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_ST_INIT;
      r_cnt   <= '0;
      r_ptr   <= c_PTR_RST;
      r_idx   <= '0;
      r_op    <= 1'b0;
      r_ff    <= 1'b0;
      r_set   <= 1'b0;
      r_reset <= 1'b0;
      r_ack   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_idx   <= w_idx_nxt;
      r_op    <= w_op_nxt;
      r_ff    <= w_ff_nxt;
      r_set   <= w_set_nxt;
      r_reset <= w_reset_nxt;
      r_ack   <= w_ack_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_idx_nxt   = r_idx;
    w_op_nxt    = r_op;
    w_ff_nxt    = r_ff;
    case (r_state)
      // First INIT cycle has reset_o still low; counting starts once it is high.
      c_ST_INIT: begin
        if (r_reset) begin
          if (r_cnt == c_P_LAST) begin
            w_state_nxt = c_ST_GAP;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + c_CNT_1;
          end
        end
      end
      c_ST_IDLE: begin
        if (w_gnt_vld) begin
          w_ptr_nxt = w_gnt_idx;
          w_idx_nxt = w_gnt_idx;
          w_op_nxt  = w_gnt_op;
          if (!w_skip) begin
            w_state_nxt = c_ST_PULSE;
            w_cnt_nxt   = '0;
            w_ff_nxt    = w_gnt_op;
          end
        end
      end
      c_ST_PULSE: begin
        if (r_cnt == c_P_LAST) begin
          w_state_nxt = c_ST_GAP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_1;
        end
      end
      c_ST_GAP: begin
        if (r_cnt == c_G_LAST) begin
          w_state_nxt = c_ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_1;
        end
      end
      default: w_state_nxt = c_ST_INIT;
    endcase
  end

  always_comb begin
    w_set_nxt   = (w_state_nxt == c_ST_PULSE) && w_op_nxt;
    w_reset_nxt = (w_state_nxt == c_ST_INIT) || ((w_state_nxt == c_ST_PULSE) && !w_op_nxt);
    w_ack_nxt   = '0;
    if ((r_state == c_ST_PULSE) && (w_state_nxt == c_ST_GAP)) begin
      w_ack_nxt = c_ONE << r_idx;
    end else if (w_gnt_vld && w_skip) begin
      w_ack_nxt = c_ONE << w_gnt_idx;
    end
  end

  assign ack      = r_ack;
  assign set_o    = r_set;
  assign reset_o  = r_reset;
  assign ff_state = r_ff;
  assign busy     = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ff_pulse_scheduler.sv
`default_nettype none
// Directed and constrained-random bench for ff_pulse_scheduler (NUM_REQ=4, P=2, G=1).
module tb_ff_pulse_scheduler;

  localparam int NUM_REQ = 4;
  localparam int P_CYC   = 2;
  localparam int G_CYC   = 1;

  logic               clk = 1'b0;
  logic               rst;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] req_op;
  logic [NUM_REQ-1:0] ack;
  logic               set_o;
  logic               reset_o;
  logic               ff_state;
  logic               busy;

  int n_checks = 0;
  int n_fail   = 0;

  ff_pulse_scheduler #(
    .NUM_REQ        (NUM_REQ),
    .PULSE_CYCLES   (P_CYC),
    .GAP_CYCLES     (G_CYC),
    .SKIP_REDUNDANT (1)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_op   (req_op),
    .ack      (ack),
    .set_o    (set_o),
    .reset_o  (reset_o),
    .ff_state (ff_state),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Invariant monitor: mutual exclusion, gap before each pulse, one-hot ack, mirror.
  logic mon_en    = 1'b0;
  logic rst_q     = 1'b0;
  logic prev_set  = 1'b0;
  logic prev_rstl = 1'b0;
  logic model_ff  = 1'b0;
  int   low_run   = 1000;

  wire logic pulse_rise = (set_o | reset_o) & ~(prev_set | prev_rstl);
  wire logic exp_ff = rst_q                 ? 1'b0 :
                      (set_o & ~prev_set)   ? 1'b1 :
                      (reset_o & ~prev_rstl) ? 1'b0 : model_ff;

  always @(posedge clk) rst_q <= rst;

  always @(negedge clk) begin
    if (mon_en) begin
      check("mutex", 32'(set_o & reset_o), 32'd0);
      check("ack_onehot", 32'($onehot0(ack)), 32'd1);
      check("mirror", 32'(ff_state), 32'(exp_ff));
      if (pulse_rise) check("gap", 32'(low_run >= G_CYC), 32'd1);
      low_run   <= (set_o | reset_o) ? 0 : low_run + 1;
      model_ff  <= exp_ff;
      prev_set  <= set_o;
      prev_rstl <= reset_o;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  int exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  logic [NUM_REQ-1:0] pend;
  logic [NUM_REQ-1:0] opl;
  logic [NUM_REQ-1:0] op_t3;
  int k;
  int idx;

  initial begin
    rst = 1'b1; req = '0; req_op = '0;
    tick(); tick();
    mon_en = 1'b1;
    rst = 1'b0;

    // T1: reset state, then INIT reset pulse, gap, idle
    check("rst_set_o", 32'(set_o), 32'd0);
    check("rst_reset_o", 32'(reset_o), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_ff", 32'(ff_state), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    tick(); check("t1_c1_reset_o", 32'(reset_o), 32'd1); check("t1_c1_ack", 32'(ack), 32'd0);
    tick(); check("t1_c2_reset_o", 32'(reset_o), 32'd1);
    tick(); check("t1_c3_reset_o", 32'(reset_o), 32'd0); check("t1_c3_busy", 32'(busy), 32'd1);
    check("t1_c3_ack", 32'(ack), 32'd0);
    tick(); check("t1_c4_busy", 32'(busy), 32'd0);

    // T2: single set request
    req = 4'b0001; req_op = 4'b0001;
    tick(); check("t2_set1", 32'(set_o), 32'd1); check("t2_ff", 32'(ff_state), 32'd1);
    check("t2_ack_early", 32'(ack), 32'd0);
    tick(); check("t2_set2", 32'(set_o), 32'd1);
    tick(); check("t2_set_off", 32'(set_o), 32'd0); check("t2_ack", 32'(ack), 32'h1);
    req = '0;
    tick(); check("t2_ack_clr", 32'(ack), 32'd0); check("t2_idle", 32'(busy), 32'd0);

    // T4: redundant set acked without a pulse
    req = 4'b0100; req_op = 4'b0100;
    tick(); check("t4_ack", 32'(ack), 32'h4); check("t4_set", 32'(set_o), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    req = '0;
    tick(); check("t4_ack_clr", 32'(ack), 32'd0); check("t4_set_after", 32'(set_o), 32'd0);

    // T5: reset during second pulse cycle aborts the transaction
    req = 4'b0001; req_op = 4'b0000;
    tick(); check("t5_p1", 32'(reset_o), 32'd1);
    tick(); check("t5_p2", 32'(reset_o), 32'd1);
    rst = 1'b1; req = '0;
    tick(); check("t5_abort_set", 32'(set_o), 32'd0); check("t5_abort_rst", 32'(reset_o), 32'd0);
    check("t5_abort_ack", 32'(ack), 32'd0); check("t5_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    tick(); check("t5_init1", 32'(reset_o), 32'd1); check("t5_ack1", 32'(ack), 32'd0);
    tick(); check("t5_init2", 32'(reset_o), 32'd1);
    tick(); check("t5_gap", 32'(reset_o), 32'd0); check("t5_no_ack", 32'(ack), 32'd0);
    tick(); check("t5_idle", 32'(busy), 32'd0);

    // T3: all requesters held; pointer restarted so order is 0,1,2,3,...
    op_t3 = 4'b1010;
    req = 4'hF; req_op = op_t3;
    k = 0;
    for (int cyc = 0; cyc < 200 && k < 8; cyc++) begin
      tick();
      if (ack != '0) begin
        idx = 0;
        for (int i = 0; i < NUM_REQ; i++) if (ack[i]) idx = i;
        check("t3_order", 32'(idx), 32'(exp_order[k]));
        check("t3_ff", 32'(ff_state), 32'(op_t3[idx]));
        k++;
      end
    end
    check("t3_done", 32'(k), 32'd8);
    req = '0;
    tick(); check("t3_idle", 32'(busy), 32'd0);

    // T6: random requests held until ack; ops stable while pending
    pend = '0; opl = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      tick();
      if (ack != '0) begin
        check("t6_ack_pending", 32'(ack & ~pend), 32'd0);
        for (int i = 0; i < NUM_REQ; i++)
          if (ack[i]) check("t6_ff", 32'(ff_state), 32'(opl[i]));
        pend = pend & ~ack;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pend[i] && ($urandom_range(3) == 0)) begin
          pend[i] = 1'b1;
          opl[i]  = 1'($urandom_range(1));
        end
      end
      req = pend; req_op = opl;
    end
    for (int cyc = 0; cyc < 100 && pend != '0; cyc++) begin
      tick();
      if (ack != '0) begin
        check("t6d_ack_pending", 32'(ack & ~pend), 32'd0);
        pend = pend & ~ack;
      end
      req = pend;
    end
    check("t6_drain", 32'(pend), 32'd0);

    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
